// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access.
// Data side has priority; fetch is protected from starvation and every access is bounded by a timeout.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        GNT_IF,
        GNT_DM,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic              bad_q, bad_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              dm_any;
    logic              done;
    logic              timed_out;

    assign dm_any    = dm_read | dm_write;
    assign timed_out = ~mem_ready & (wait_q == WAIT_LAST);
    assign done      = mem_ready | timed_out;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        bad_d       = bad_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Fetch only overrides a pending data access once it has waited STARVE_MAX grants.
                if (if_req && (!dm_any || starve_q == STARVE_LIM)) begin
                    state_d    = GNT_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    bad_d      = 1'b0;
                    wait_d     = '0;
                    starve_d   = '0;
                end else if (dm_any) begin
                    state_d     = GNT_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_write;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    bad_d       = dm_read & dm_write;
                    wait_d      = '0;
                    starve_d    = if_req ? starve_q + SW'(1) : '0;
                end else begin
                    starve_d = '0;
                end
            end
            GNT_IF, GNT_DM: begin
                if (done) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == GNT_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = timed_out ? '0 : mem_rdata;
                        err_d      = timed_out;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = (timed_out || mem_we_q) ? '0 : mem_rdata;
                        err_d      = timed_out | bad_q;
                    end
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            bad_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            bad_q       <= bad_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign err       = err_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_dm  = dm_any & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 15;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_dm;
    logic              err;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_dm(stall_dm), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // memory responder knobs
    int          force_delay    = -1;
    int          cur_delay      = 0;
    int          mem_wait       = 0;
    bit          spurious_en    = 0;
    bit          fixed_rdata_en = 0;
    logic [31:0] fixed_rdata    = '0;

    // model: owner 0=none 1=fetch 2=data; resp holds the side acked this cycle
    int          m_owner   = 0;
    int          m_resp    = 0;
    int          m_waited  = 0;
    int          m_starve  = 0;
    logic [31:0] m_addr    = '0;
    logic [31:0] m_wdata   = '0;
    logic [31:0] m_rdata   = '0;
    logic        m_we      = 0;
    logic        m_bad     = 0;
    logic        m_err     = 0;
    logic        m_in_rst  = 1;

    // results of the last waitAck call
    int          w_side;
    int          w_cycles;
    int          w_req_cycles;
    logic [31:0] w_addr;
    logic        w_we;
    logic [31:0] w_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        logic dm_any;
        dm_any = dm_read | dm_write;
        if (!rst_n) begin
            m_owner = 0; m_resp = 0; m_starve = 0; m_waited = 0; m_in_rst = 1;
            return;
        end
        m_in_rst = 0;
        if (m_resp != 0) begin
            m_resp = 0;
        end else if (m_owner != 0) begin
            m_waited++;
            if (mem_ready) begin
                m_resp  = m_owner;
                m_err   = m_bad;
                m_rdata = (m_owner == 2 && m_we) ? 32'h0 : mem_rdata;
                m_owner = 0;
            end else if (m_waited >= TIMEOUT) begin
                m_resp  = m_owner;
                m_err   = 1;
                m_rdata = 32'h0;
                m_owner = 0;
            end
        end else if (if_req && (!dm_any || m_starve == STARVE_MAX)) begin
            m_owner = 1; m_addr = if_addr; m_we = 0; m_bad = 0; m_waited = 0; m_starve = 0;
        end else if (dm_any) begin
            m_owner = 2; m_addr = dm_addr; m_wdata = dm_wdata; m_we = dm_write;
            m_bad = dm_read & dm_write; m_waited = 0;
            m_starve = if_req ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
        end else begin
            m_starve = 0;
        end
    endtask

    // Advance the model on each edge, then compare the settled DUT outputs.
    always @(posedge clk) begin
        modelStep();
        #1;
        checkOutput("mem_req", 64'(mem_req), 64'(m_owner != 0));
        checkOutput("mem_we", 64'(mem_we), 64'(m_owner != 0 && m_we));
        checkOutput("if_ack", 64'(if_ack), 64'(m_resp == 1));
        checkOutput("dm_ack", 64'(dm_ack), 64'(m_resp == 2));
        checkOutput("err", 64'(err), 64'(m_resp != 0 && m_err));
        checkOutput("stall_if", 64'(stall_if), 64'(if_req && m_resp != 1));
        checkOutput("stall_dm", 64'(stall_dm), 64'((dm_read || dm_write) && m_resp != 2));
        if (m_owner != 0) checkOutput("mem_addr", 64'(mem_addr), 64'(m_addr));
        if (m_owner == 2 && m_we) checkOutput("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        if (m_resp == 1) checkOutput("if_rdata", 64'(if_rdata), 64'(m_rdata));
        if (m_resp == 2) checkOutput("dm_rdata", 64'(dm_rdata), 64'(m_rdata));
        if (m_in_rst) begin
            checkOutput("rst_mem_addr", 64'(mem_addr), 64'h0);
            checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'h0);
            checkOutput("rst_if_rdata", 64'(if_rdata), 64'h0);
            checkOutput("rst_dm_rdata", 64'(dm_rdata), 64'h0);
        end
    end

    task automatic tickMem();
        if (mem_req) begin
            if (mem_wait == 0)
                cur_delay = (force_delay >= 0) ? force_delay :
                            (($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3)));
            mem_ready = (mem_wait >= cur_delay);
            mem_wait++;
        end else begin
            mem_wait  = 0;
            mem_ready = spurious_en && ($urandom_range(0, 7) == 0);
        end
        mem_rdata = fixed_rdata_en ? fixed_rdata : $urandom;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clk);
            tickMem();
        end
    endtask

    task automatic waitAck(input int limit);
        w_side = 0; w_cycles = 0; w_req_cycles = 0; w_addr = '0; w_we = 0; w_wdata = '0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (mem_req) begin
                if (w_req_cycles == 0) begin
                    w_addr = mem_addr; w_we = mem_we; w_wdata = mem_wdata;
                end
                w_req_cycles++;
            end
            tickMem();
            if (if_ack || dm_ack) begin
                w_side   = if_ack ? 1 : 2;
                w_cycles = i;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("[TB] FAIL ack_wait: no ack within %0d cycles, expected one", limit);
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        tickMem();
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
        if (if_ack || !if_req) begin
            if_req  = ($urandom_range(0, 2) == 0);
            if_addr = $urandom;
        end
        if (dm_ack || !(dm_read || dm_write)) begin
            case ($urandom_range(0, 7))
                0, 1:    begin dm_read = 1'b1; dm_write = 1'b0; end
                2, 3:    begin dm_read = 1'b0; dm_write = 1'b1; end
                4:       begin dm_read = 1'b1; dm_write = 1'b1; end
                default: begin dm_read = 1'b0; dm_write = 1'b0; end
            endcase
            dm_addr  = $urandom;
            dm_wdata = $urandom;
        end
    endtask

    initial begin
        int data_grants;
        int fetch_pos;
        bit ack_seen;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_read = 1'b0; dm_write = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_mem_req", 64'(mem_req), 64'h0);
        checkOutput("reset_mem_addr", 64'(mem_addr), 64'h0);

        // single fetch, memory answers in the first grant cycle
        $display("[TB] directed fetch");
        rst_n = 1'b1; force_delay = 0; fixed_rdata_en = 1; fixed_rdata = 32'h2002000A;
        if_req = 1'b1; if_addr = 32'h40;
        waitAck(10);
        checkOutput("fetch_side", 64'(w_side), 64'd1);
        checkOutput("fetch_latency", 64'(w_cycles), 64'd2);
        checkOutput("fetch_req_cycles", 64'(w_req_cycles), 64'd1);
        checkOutput("fetch_addr", 64'(w_addr), 64'h40);
        checkOutput("fetch_rdata", 64'(if_rdata), 64'h2002000A);
        if_req = 1'b0; fixed_rdata_en = 0;

        // simultaneous fetch and load: data goes first
        quiet(1);
        $display("[TB] directed priority");
        force_delay = 1; if_req = 1'b1; if_addr = 32'h80; dm_read = 1'b1; dm_addr = 32'h100;
        waitAck(20);
        checkOutput("prio_first_side", 64'(w_side), 64'd2);
        checkOutput("prio_first_addr", 64'(w_addr), 64'h100);
        checkOutput("prio_stall_if", 64'(stall_if), 64'h1);
        dm_read = 1'b0;
        waitAck(20);
        checkOutput("prio_second_side", 64'(w_side), 64'd1);
        checkOutput("prio_second_addr", 64'(w_addr), 64'h80);
        if_req = 1'b0;

        // continuous stores against a waiting fetch
        quiet(1);
        $display("[TB] directed starvation");
        force_delay = 0; if_req = 1'b1; if_addr = 32'h200; dm_write = 1'b1; dm_addr = 32'h400;
        data_grants = 0; fetch_pos = 0;
        for (int k = 1; k <= 8; k++) begin
            waitAck(20);
            if (w_side == 2) begin
                data_grants++;
                dm_addr = dm_addr + 32'd4;
            end else begin
                fetch_pos = k;
                if_req = 1'b0;
                break;
            end
        end
        checkOutput("starve_data_grants", 64'(data_grants), 64'd4);
        checkOutput("starve_fetch_pos", 64'(fetch_pos), 64'd5);
        dm_write = 1'b0;

        // load with a memory that never answers
        quiet(1);
        $display("[TB] directed timeout");
        force_delay = 100; dm_read = 1'b1; dm_addr = 32'h500;
        waitAck(40);
        checkOutput("timeout_side", 64'(w_side), 64'd2);
        checkOutput("timeout_req_cycles", 64'(w_req_cycles), 64'd15);
        checkOutput("timeout_err", 64'(err), 64'h1);
        checkOutput("timeout_rdata", 64'(dm_rdata), 64'h0);
        dm_read = 1'b0;

        // read and write together
        quiet(1);
        $display("[TB] directed read+write");
        force_delay = 0; dm_read = 1'b1; dm_write = 1'b1; dm_wdata = 32'hABCD; dm_addr = 32'h600;
        waitAck(20);
        checkOutput("rw_we", 64'(w_we), 64'h1);
        checkOutput("rw_wdata", 64'(w_wdata), 64'hABCD);
        checkOutput("rw_err", 64'(err), 64'h1);
        checkOutput("rw_rdata", 64'(dm_rdata), 64'h0);
        dm_read = 1'b0; dm_write = 1'b0;

        // reset while a load is granted
        quiet(1);
        $display("[TB] directed reset mid-access");
        force_delay = 100; dm_read = 1'b1; dm_addr = 32'h700;
        @(negedge clk);
        tickMem();
        checkOutput("rstmid_req_before", 64'(mem_req), 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_req_after", 64'(mem_req), 64'h0);
        rst_n = 1'b1; dm_read = 1'b0; mem_ready = 1'b1;
        ack_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (dm_ack) ack_seen = 1;
        end
        checkOutput("rstmid_no_ack", 64'(ack_seen), 64'h0);
        mem_ready = 1'b0;

        $display("[TB] random traffic");
        force_delay = -1; spurious_en = 1;
        repeat (4000) applyStimulus();

        @(negedge clk);
        rst_n = 1'b1; if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; spurious_en = 0;
        quiet(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
